// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS split-transaction bus bridges (data and instruction side).
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bus_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Load data returned when a bus transaction is abandoned by the watchdog.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/be_to_size.sv
// Byte-enable to bus transfer size decoder; unrecognised patterns fall back to a word access.
module be_to_size
    import mips_bus_pkg::*;
(
    input  logic [3:0] be_i,
    output logic [1:0] size_o
);

    always_comb begin
        case (be_i)
            4'b1111:                            size_o = SIZE_WORD;
            4'b0011, 4'b1100:                   size_o = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SIZE_BYTE;
            default:                            size_o = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Memory-stage to SRAM-like (req/addr_ok/data_ok) bridge with stall and flush handling.
// Define DMEM_TIMEOUT_EN to enable the data_ok watchdog that drives bus_err_o.
module dmem_sram_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ren_i,
    input  logic [3:0]        wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              bus_err_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    typedef logic [CNT_W-1:0] tmo_cnt_t;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, live_req, cur_req;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              flushed_q, flushed_d;
    logic              acc, is_wr, issue, accept, complete, discard, timeout_hit;
    logic [3:0]        act_be;
    logic [1:0]        live_size;

    assign is_wr  = |wen_i;
    assign acc    = (|ren_i | is_wr) & ~flush_i;
    assign act_be = is_wr ? wen_i : ren_i;

    be_to_size u_be_to_size (
        .be_i   (act_be),
        .size_o (live_size)
    );

    assign live_req = '{wr: is_wr, size: live_size, addr: addr_i, wdata: wdata_i};
    // In IDLE the request goes out combinationally; afterwards the captured copy holds the bus stable.
    assign cur_req  = (state_q == IDLE) ? live_req : req_q;

    assign issue    = ((state_q == IDLE) & acc) | ((state_q == REQ) & ~flush_i);
    assign accept   = issue & data_addr_ok;
    assign complete = (accept & data_data_ok) | ((state_q == WAIT) & data_data_ok);
    assign discard  = (state_q == WAIT) & (flushed_q | flush_i);

`ifdef DMEM_TIMEOUT_EN
    tmo_cnt_t tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (((state_q == REQ) & ~flush_i) | (state_q == WAIT))
                       & (tmo_cnt_q == tmo_cnt_t'(TIMEOUT_CYCLES - 1)) & ~complete;
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus_err_o = timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: all clocked state updates use <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (acc) state_d = complete ? DONE : (accept ? WAIT : REQ);
            REQ: begin
                if (flush_i)                       state_d = IDLE;
                else if (complete || timeout_hit)  state_d = DONE;
                else if (accept)                   state_d = WAIT;
            end
            WAIT: if (complete || timeout_hit) state_d = discard ? IDLE : DONE;
            DONE: if (flush_i || !pipe_stall_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_req   = issue;
        data_wr    = cur_req.wr;
        data_size  = cur_req.size;
        data_addr  = cur_req.addr;
        data_wdata = cur_req.wdata;
        case (state_q)
            IDLE:    stall_o = acc & ~complete;
            REQ:     stall_o = acc & ~complete & ~timeout_hit;
            WAIT:    stall_o = ~complete & ~timeout_hit;
            default: stall_o = 1'b0;
        endcase
    end

    // A flush seen while waiting for data_ok must survive until the response is absorbed.
    assign flushed_d = (state_d == WAIT) & (flush_i | flushed_q);

    always_comb begin
        rdata_d = rdata_q;
        if (complete && !cur_req.wr && !discard) begin
            rdata_d = data_rdata;
        end else if (timeout_hit && !discard) begin
            rdata_d = DATA_W'(TIMEOUT_RDATA);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= '0;
            flushed_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            flushed_q <= flushed_d;
        end
    end

    // NOTE: the request copy is only read outside IDLE, after it has been loaded, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && acc) begin
            req_q <= live_req;
        end
    end

    assign rdata_o = rdata_q;

endmodule
